forward_history_check: RTL

- Parametrised operand-bypass block for the execute-stage operand read.
- For NUM_SRC source operands it selects forwarded data from NUM_BYPASS live bypass channels or from a HIST_DEPTH-deep registered history of earlier bypass results; otherwise it passes register-file data through.
- Sits between the register-read pipeline register and the functional-unit operand inputs.
- Adds deterministic multi-match priority, history retention, flush/hold, and conflict reporting.

---
 rtl/forward_history_check.sv | 136 +++++++++++++
 1 files changed

// File: rtl/forward_history_check.sv
// Execute-stage operand bypass: per-operand priority lookup across live bypass
// channels and a shifting history of earlier bypass results, with conflict flags.
module forward_history_check #(
  parameter int unsigned SIZE_DATA         = 32,
  parameter int unsigned SIZE_PHYSICAL_LOG = 7,
  parameter int unsigned NUM_BYPASS        = 4,
  parameter int unsigned HIST_DEPTH        = 2,
  parameter int unsigned NUM_SRC           = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    hold_i,
  input  logic                                    flush_i,
  input  logic [NUM_BYPASS-1:0]                   bypassValid_i,
  input  logic [NUM_BYPASS*SIZE_PHYSICAL_LOG-1:0] bypassTag_i,
  input  logic [NUM_BYPASS*SIZE_DATA-1:0]         bypassData_i,
  input  logic [NUM_SRC*SIZE_PHYSICAL_LOG-1:0]    srcReg_i,
  input  logic [NUM_SRC*SIZE_DATA-1:0]            srcData_i,
  output logic [NUM_SRC*SIZE_DATA-1:0]            dataOut_o,
  output logic [NUM_SRC-1:0]                      fwdHit_o,
  output logic                                    conflict_o,
  output logic                                    conflictSticky_o
);

  localparam int unsigned T       = SIZE_PHYSICAL_LOG;
  localparam int unsigned W       = SIZE_DATA;
  localparam int unsigned NUM_STG = HIST_DEPTH + 1;

  // Stage 0 is the live bypass bus, stage k is history stage k.
  logic [NUM_BYPASS-1:0]   stg_vld  [NUM_STG];
  logic [NUM_BYPASS*T-1:0] stg_tag  [NUM_STG];
  logic [NUM_BYPASS*W-1:0] stg_data [NUM_STG];

  logic conflict_sticky_q, conflict_sticky_d;

  if (HIST_DEPTH > 0) begin : g_hist
    logic [NUM_BYPASS-1:0]   hist_vld_q  [HIST_DEPTH];
    logic [NUM_BYPASS-1:0]   hist_vld_d  [HIST_DEPTH];
    logic [NUM_BYPASS*T-1:0] hist_tag_q  [HIST_DEPTH];
    logic [NUM_BYPASS*W-1:0] hist_data_q [HIST_DEPTH];
    logic                    shift_en;

    assign shift_en = !flush_i && !hold_i;

    always_comb begin
      hist_vld_d = hist_vld_q;
      if (flush_i) begin
        for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_vld_d[k] = '0;
      end else if (!hold_i) begin
        hist_vld_d[0] = bypassValid_i;
        for (int unsigned k = 1; k < HIST_DEPTH; k++) hist_vld_d[k] = hist_vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int unsigned k = 0; k < HIST_DEPTH; k++) hist_vld_q[k] <= '0;
      end else begin
        hist_vld_q <= hist_vld_d;
      end
    end

    // Tag/data are qualified by valid, so they only load on a shift.
    always_ff @(posedge clk) begin
      if (reset && shift_en) begin
        hist_tag_q[0]  <= bypassTag_i;
        hist_data_q[0] <= bypassData_i;
        for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
          hist_tag_q[k]  <= hist_tag_q[k-1];
          hist_data_q[k] <= hist_data_q[k-1];
        end
      end
    end

    always_comb begin
      stg_vld[0]  = bypassValid_i;
      stg_tag[0]  = bypassTag_i;
      stg_data[0] = bypassData_i;
      for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
        stg_vld[k+1]  = hist_vld_q[k];
        stg_tag[k+1]  = hist_tag_q[k];
        stg_data[k+1] = hist_data_q[k];
      end
    end
  end else begin : g_live_only
    always_comb begin
      stg_vld[0]  = bypassValid_i;
      stg_tag[0]  = bypassTag_i;
      stg_data[0] = bypassData_i;
    end
  end

  // Youngest stage with any match wins; inside it the lowest channel wins.
  always_comb begin : lookup
    logic [T-1:0] src_tag;
    logic         found;
    logic         stage_hit;
    dataOut_o  = srcData_i;
    fwdHit_o   = '0;
    conflict_o = 1'b0;
    src_tag    = '0;
    found      = 1'b0;
    stage_hit  = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      src_tag = srcReg_i[s*T +: T];
      found   = 1'b0;
      for (int unsigned st = 0; st < NUM_STG; st++) begin
        stage_hit = 1'b0;
        if (!found) begin
          for (int unsigned c = 0; c < NUM_BYPASS; c++) begin
            if (stg_vld[st][c] && (stg_tag[st][c*T +: T] == src_tag)) begin
              if (stage_hit) begin
                conflict_o = 1'b1;
              end else begin
                dataOut_o[s*W +: W] = stg_data[st][c*W +: W];
                fwdHit_o[s]         = 1'b1;
              end
              stage_hit = 1'b1;
            end
          end
        end
        if (stage_hit) found = 1'b1;
      end
    end
  end

  assign conflict_sticky_d = conflict_sticky_q | conflict_o;

  always_ff @(posedge clk) begin
    if (!reset) conflict_sticky_q <= 1'b0;
    else        conflict_sticky_q <= conflict_sticky_d;
  end

  assign conflictSticky_o = conflict_sticky_q;

endmodule
